// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss-handling control FSM for the 2-way set-associative L1 cache.
//
// Hits resolve combinationally in IDLE (mem_resp in the request cycle). A miss latches the
// LRU way as the victim. If the victim is valid and dirty, the FSM writes it back
// (WRITEBACK) and then refills it (FILL). Otherwise it goes straight to FILL. After the
// refill the FSM returns to IDLE, where the held request now hits.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   mem_read, mem_write          CPU request strobes (held until mem_resp)
//   mem_resp                     CPU request complete (hit cycle)
//   tag0_hit, tag1_hit           per-way valid-and-tag-match of the addressed set
//   lru_way                      LRU way of the addressed set
//   valid0/1, dirty0/1           per-way status bits of the addressed set
//   lru_load                     LRU tracker update strobe (hit cycles only)
//   way_sel                      way addressed by the datapath this cycle
//   wb_addr_sel                  1: pmem address from victim tag, 0: from CPU tag
//   line_load, tag_load,
//   valid_set, dirty_set,
//   dirty_clr                    datapath write strobes for way_sel
//   pmem_read, pmem_write        physical-memory request, held until pmem_resp
//   pmem_resp                    physical-memory done pulse
//   miss_count, wb_count         saturating miss / writeback statistics
module cache_miss_ctrl #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             tag0_hit,
  input  logic             tag1_hit,
  input  logic             lru_way,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             dirty0,
  input  logic             dirty1,
  output logic             lru_load,
  output logic             way_sel,
  output logic             wb_addr_sel,
  output logic             line_load,
  output logic             tag_load,
  output logic             valid_set,
  output logic             dirty_set,
  output logic             dirty_clr,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  // The set index of the datapath (lc3b_set) is 4 bits wide.
  if (NUM_SETS != 16) begin : g_num_sets_check
    $error("cache_miss_ctrl: NUM_SETS must be 16");
  end

  typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

  state_e state_q, state_d;
  logic   victim_q, victim_d;
  logic   miss_inc, wb_inc;
  logic   victim_dirty;

  assign victim_dirty = lru_way ? (valid1 & dirty1) : (valid0 & dirty0);

  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    miss_inc    = 1'b0;
    wb_inc      = 1'b0;
    mem_resp    = 1'b0;
    lru_load    = 1'b0;
    way_sel     = 1'b0;
    wb_addr_sel = 1'b0;
    line_load   = 1'b0;
    tag_load    = 1'b0;
    valid_set   = 1'b0;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gating with reset_n keeps the Mealy hit outputs low while reset is asserted.
        if (reset_n && (mem_read || mem_write)) begin
          if (tag0_hit || tag1_hit) begin
            mem_resp = 1'b1;
            lru_load = 1'b1;
            way_sel  = ~tag0_hit;  // way 0 wins if both ways report a hit
            if (mem_write) begin
              line_load = 1'b1;
              dirty_set = 1'b1;
            end
          end else begin
            victim_d = lru_way;
            miss_inc = 1'b1;
            if (victim_dirty) begin
              wb_inc  = 1'b1;
              state_d = StWriteback;
            end else begin
              state_d = StFill;
            end
          end
        end
      end

      StWriteback: begin
        pmem_write  = 1'b1;
        wb_addr_sel = 1'b1;
        way_sel     = victim_q;
        if (pmem_resp) begin
          dirty_clr = 1'b1;
          state_d   = StFill;
        end
      end

      StFill: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          line_load = 1'b1;
          tag_load  = 1'b1;
          valid_set = 1'b1;
          dirty_clr = 1'b1;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
      if (wb_inc && (wb_count != '1))     wb_count   <= wb_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl. Inputs change just after the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
// A second instance with 4-bit counters covers counter saturation in a short run.
module tb_cache_miss_ctrl;

  logic clk;
  logic reset_n;
  logic mem_read, mem_write, tag0_hit, tag1_hit, lru_way;
  logic valid0, valid1, dirty0, dirty1, pmem_resp;
  logic mem_resp, lru_load, way_sel, wb_addr_sel, line_load, tag_load;
  logic valid_set, dirty_set, dirty_clr, pmem_read, pmem_write;
  logic [15:0] miss_count, wb_count;

  logic s_reset_n, s_mem_read, s_pmem_resp;
  logic s_mem_resp, s_lru_load, s_way_sel, s_wb_addr_sel, s_line_load, s_tag_load;
  logic s_valid_set, s_dirty_set, s_dirty_clr, s_pmem_read, s_pmem_write;
  logic [3:0] s_miss_count, s_wb_count;

  int passed;
  int total;

  cache_miss_ctrl #(.NUM_SETS(16), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .tag0_hit(tag0_hit), .tag1_hit(tag1_hit), .lru_way(lru_way),
    .valid0(valid0), .valid1(valid1), .dirty0(dirty0), .dirty1(dirty1),
    .lru_load(lru_load), .way_sel(way_sel), .wb_addr_sel(wb_addr_sel),
    .line_load(line_load), .tag_load(tag_load), .valid_set(valid_set),
    .dirty_set(dirty_set), .dirty_clr(dirty_clr), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  // Every request misses on a dirty victim: one miss and one writeback every 3 cycles.
  cache_miss_ctrl #(.NUM_SETS(16), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(s_reset_n), .mem_read(s_mem_read), .mem_write(1'b0),
    .mem_resp(s_mem_resp), .tag0_hit(1'b0), .tag1_hit(1'b0), .lru_way(1'b0),
    .valid0(1'b1), .valid1(1'b0), .dirty0(1'b1), .dirty1(1'b0),
    .lru_load(s_lru_load), .way_sel(s_way_sel), .wb_addr_sel(s_wb_addr_sel),
    .line_load(s_line_load), .tag_load(s_tag_load), .valid_set(s_valid_set),
    .dirty_set(s_dirty_set), .dirty_clr(s_dirty_clr), .pmem_read(s_pmem_read),
    .pmem_write(s_pmem_write), .pmem_resp(s_pmem_resp), .miss_count(s_miss_count),
    .wb_count(s_wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    mem_read = 0; mem_write = 0; tag0_hit = 0; tag1_hit = 0; lru_way = 0;
    valid0 = 0; valid1 = 0; dirty0 = 0; dirty1 = 0; pmem_resp = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset_n = 0;
    mem_read = 1; tag0_hit = 1;  // a hit presented during reset must stay silent
    repeat (2) @(negedge clk);
    #1;
    total++; if (mem_resp !== 1'b0) $display("FAIL rst_mem_resp: got %b want 0", mem_resp); else passed++;
    total++; if (lru_load !== 1'b0) $display("FAIL rst_lru_load: got %b want 0", lru_load); else passed++;
    total++; if (miss_count !== 16'h0) $display("FAIL rst_miss_count: got %h want 0000", miss_count); else passed++;
    total++; if (wb_count !== 16'h0) $display("FAIL rst_wb_count: got %h want 0000", wb_count); else passed++;
    total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL rst_pmem: got %b want 00", {pmem_read, pmem_write}); else passed++;
    @(negedge clk);
    clear_inputs();
    reset_n = 1;
  endtask

  task automatic test_read_hit;
    @(negedge clk);
    mem_read = 1; tag1_hit = 1;
    #1;
    total++; if (mem_resp !== 1'b1) $display("FAIL rdhit_mem_resp: got %b want 1", mem_resp); else passed++;
    total++; if (lru_load !== 1'b1) $display("FAIL rdhit_lru_load: got %b want 1", lru_load); else passed++;
    total++; if (way_sel !== 1'b1) $display("FAIL rdhit_way_sel: got %b want 1", way_sel); else passed++;
    total++; if ({dirty_set, line_load} !== 2'b00) $display("FAIL rdhit_writes: got %b want 00", {dirty_set, line_load}); else passed++;
    @(negedge clk);
    clear_inputs();
    #1;
    total++; if (mem_resp !== 1'b0) $display("FAIL idle_mem_resp: got %b want 0", mem_resp); else passed++;
    total++; if (miss_count !== 16'h0) $display("FAIL rdhit_miss_count: got %h want 0000", miss_count); else passed++;
  endtask

  task automatic test_write_hit;
    @(negedge clk);
    mem_write = 1; tag0_hit = 1;
    #1;
    total++; if (mem_resp !== 1'b1) $display("FAIL wrhit_mem_resp: got %b want 1", mem_resp); else passed++;
    total++; if ({line_load, dirty_set} !== 2'b11) $display("FAIL wrhit_writes: got %b want 11", {line_load, dirty_set}); else passed++;
    total++; if (way_sel !== 1'b0) $display("FAIL wrhit_way_sel: got %b want 0", way_sel); else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_both_hits;
    @(negedge clk);
    mem_read = 1; tag0_hit = 1; tag1_hit = 1;
    #1;
    total++; if (way_sel !== 1'b0) $display("FAIL bothhit_way_sel: got %b want 0", way_sel); else passed++;
    total++; if (mem_resp !== 1'b1) $display("FAIL bothhit_mem_resp: got %b want 1", mem_resp); else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_clean_miss;
    @(negedge clk);
    mem_read = 1; lru_way = 1; valid1 = 1; dirty1 = 0;
    #1;
    total++; if ({mem_resp, lru_load} !== 2'b00) $display("FAIL cm_miss_cycle: got %b want 00", {mem_resp, lru_load}); else passed++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 3) pmem_resp = 1;
      #1;
      total++; if ({pmem_read, pmem_write} !== 2'b10) $display("FAIL cm_pmem_c%0d: got %b want 10", i, {pmem_read, pmem_write}); else passed++;
      total++; if ({way_sel, wb_addr_sel, lru_load} !== 3'b100) $display("FAIL cm_sel_c%0d: got %b want 100", i, {way_sel, wb_addr_sel, lru_load}); else passed++;
    end
    total++; if ({line_load, tag_load, valid_set, dirty_clr} !== 4'b1111) $display("FAIL cm_fill_strobes: got %b want 1111", {line_load, tag_load, valid_set, dirty_clr}); else passed++;
    total++; if (miss_count !== 16'd1) $display("FAIL cm_miss_count: got %h want 0001", miss_count); else passed++;
    total++; if (wb_count !== 16'd0) $display("FAIL cm_wb_count: got %h want 0000", wb_count); else passed++;
    @(negedge clk);
    pmem_resp = 0; tag1_hit = 1;
    #1;
    total++; if (pmem_read !== 1'b0) $display("FAIL cm_pmem_fall: got %b want 0", pmem_read); else passed++;
    total++; if ({mem_resp, lru_load, way_sel} !== 3'b111) $display("FAIL cm_rehit: got %b want 111", {mem_resp, lru_load, way_sel}); else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_dirty_miss;
    @(negedge clk);
    mem_write = 1; lru_way = 0; valid0 = 1; dirty0 = 1;
    @(negedge clk);
    lru_way = 1;  // LRU flips mid-writeback; the latched victim must not follow
    #1;
    total++; if ({pmem_write, pmem_read} !== 2'b10) $display("FAIL dm_wb_pmem: got %b want 10", {pmem_write, pmem_read}); else passed++;
    total++; if ({wb_addr_sel, way_sel, lru_load} !== 3'b100) $display("FAIL dm_wb_sel: got %b want 100", {wb_addr_sel, way_sel, lru_load}); else passed++;
    total++; if (wb_count !== 16'd1) $display("FAIL dm_wb_count: got %h want 0001", wb_count); else passed++;
    total++; if (miss_count !== 16'd2) $display("FAIL dm_miss_count: got %h want 0002", miss_count); else passed++;
    @(negedge clk);
    pmem_resp = 1;
    #1;
    total++; if ({dirty_clr, pmem_write, way_sel} !== 3'b110) $display("FAIL dm_wb_done: got %b want 110", {dirty_clr, pmem_write, way_sel}); else passed++;
    @(negedge clk);
    pmem_resp = 0;
    #1;
    total++; if ({pmem_read, pmem_write} !== 2'b10) $display("FAIL dm_fill_pmem: got %b want 10", {pmem_read, pmem_write}); else passed++;
    total++; if ({way_sel, wb_addr_sel, dirty_clr} !== 3'b000) $display("FAIL dm_fill_sel: got %b want 000", {way_sel, wb_addr_sel, dirty_clr}); else passed++;
    @(negedge clk);
    pmem_resp = 1;
    #1;
    total++; if ({line_load, tag_load, way_sel} !== 3'b110) $display("FAIL dm_fill_done: got %b want 110", {line_load, tag_load, way_sel}); else passed++;
    @(negedge clk);
    pmem_resp = 0; tag0_hit = 1;
    #1;
    total++; if ({mem_resp, dirty_set, way_sel} !== 3'b110) $display("FAIL dm_rehit: got %b want 110", {mem_resp, dirty_set, way_sel}); else passed++;
    total++; if (wb_count !== 16'd1) $display("FAIL dm_wb_count_end: got %h want 0001", wb_count); else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_abandoned;
    @(negedge clk);
    mem_read = 1; lru_way = 1; valid1 = 0;
    @(negedge clk);
    mem_read = 0;
    #1;
    total++; if (pmem_read !== 1'b1) $display("FAIL ab_pmem_read: got %b want 1", pmem_read); else passed++;
    @(negedge clk);
    pmem_resp = 1;
    #1;
    total++; if ({line_load, valid_set, way_sel, mem_resp} !== 4'b1110) $display("FAIL ab_fill: got %b want 1110", {line_load, valid_set, way_sel, mem_resp}); else passed++;
    @(negedge clk);
    pmem_resp = 0;
    #1;
    total++; if ({pmem_read, mem_resp} !== 2'b00) $display("FAIL ab_idle: got %b want 00", {pmem_read, mem_resp}); else passed++;
    total++; if (miss_count !== 16'd3) $display("FAIL ab_miss_count: got %h want 0003", miss_count); else passed++;
    // Stray pmem_resp in IDLE must be ignored.
    @(negedge clk);
    pmem_resp = 1;
    #1;
    total++; if ({dirty_clr, line_load, pmem_read} !== 3'b000) $display("FAIL idle_resp_strobes: got %b want 000", {dirty_clr, line_load, pmem_read}); else passed++;
    @(negedge clk);
    pmem_resp = 0;
    #1;
    total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL idle_resp_state: got %b want 00", {pmem_read, pmem_write}); else passed++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_fill;
    @(negedge clk);
    mem_read = 1; lru_way = 1; valid1 = 0;
    @(negedge clk);
    #1;
    total++; if ({pmem_read, way_sel} !== 2'b11) $display("FAIL rf_pre: got %b want 11", {pmem_read, way_sel}); else passed++;
    #1;
    reset_n = 0;  // asynchronous, mid-cycle
    #1;
    total++; if (pmem_read !== 1'b0) $display("FAIL rf_pmem_read: got %b want 0", pmem_read); else passed++;
    total++; if ({miss_count, wb_count} !== 32'h0) $display("FAIL rf_counts: got %h want 00000000", {miss_count, wb_count}); else passed++;
    total++; if (dut.victim_q !== 1'b0) $display("FAIL rf_victim: got %b want 0", dut.victim_q); else passed++;
    total++; if (mem_resp !== 1'b0) $display("FAIL rf_mem_resp: got %b want 0", mem_resp); else passed++;
    @(negedge clk);
    clear_inputs();
    reset_n = 1;
    #1;
    total++; if (pmem_read !== 1'b0) $display("FAIL rf_post_pmem: got %b want 0", pmem_read); else passed++;
    @(negedge clk);
    mem_read = 1; tag0_hit = 1;
    #1;
    total++; if (mem_resp !== 1'b1) $display("FAIL rf_post_idle_hit: got %b want 1", mem_resp); else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_saturation;
    @(negedge clk);
    s_reset_n = 1;
    repeat (42) @(posedge clk);
    #1;
    total++; if (s_miss_count !== 4'd14) $display("FAIL sat_miss_14: got %0d want 14", s_miss_count); else passed++;
    total++; if (s_wb_count !== 4'd14) $display("FAIL sat_wb_14: got %0d want 14", s_wb_count); else passed++;
    repeat (6) @(posedge clk);
    #1;
    total++; if (s_miss_count !== 4'hF) $display("FAIL sat_miss_hold: got %0d want 15", s_miss_count); else passed++;
    total++; if (s_wb_count !== 4'hF) $display("FAIL sat_wb_hold: got %0d want 15", s_wb_count); else passed++;
    repeat (9) @(posedge clk);
    #1;
    total++; if (s_miss_count !== 4'hF) $display("FAIL sat_miss_late: got %0d want 15", s_miss_count); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    s_reset_n = 0;
    s_mem_read = 1;
    s_pmem_resp = 1;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_both_hits();
    test_clean_miss();
    test_dirty_miss();
    test_abandoned();
    test_reset_mid_fill();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
